// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
//   HTRANS_* : AHB transfer-type encodings.
//   arb_state_e : arbiter FSM states.
//   is_beat_trans : true for transfer types that move data (NONSEQ, SEQ).
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_OWN     = 2'b01,
        ARB_REFRESH = 2'b10
    } arb_state_e;

    function automatic logic is_beat_trans(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_sdram_burst_arbiter_if.sv
// Bundle between the multi-master wrapper and the SDRAM port arbiter.
//   slave  : arbiter view (samples requests/HTRANS/HREADY/refresh, drives grant side)
//   master : wrapper view (drives requests/HTRANS/HREADY/refresh, samples grant side)
interface ahb_sdram_burst_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0]   req;
    logic [2*NUM_MASTERS-1:0] htrans;
    logic                     hready_shared;
    logic                     refresh_req;
    logic                     refresh_done;
    logic [NUM_MASTERS-1:0]   grant;
    logic                     grant_valid;
    logic [IDX_W-1:0]         owner_idx;
    logic                     refresh_ack;
    logic                     addr_block;

    modport slave (
        input  req, htrans, hready_shared, refresh_req, refresh_done,
        output grant, grant_valid, owner_idx, refresh_ack, addr_block
    );

    modport master (
        output req, htrans, hready_shared, refresh_req, refresh_done,
        input  grant, grant_valid, owner_idx, refresh_ack, addr_block
    );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first set bit of req searching from rr_ptr upward,
// wrapping at NUM_MASTERS.
//   req    : per-master request vector
//   rr_ptr : index searched first
//   winner : index of the selected master (0 when none)
//   found  : at least one request present
module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   found
);

    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_sdram_burst_arbiter.sv
// Round-robin, burst-aware owner of the shared sdram_controller AHB port.
// Ownership is only given up at an AHB transfer boundary; a beat quota and pending
// refresh force release at the next NONSEQ, and refresh windows outrank all masters.
//   hclk, hreset : clock, synchronous active-high reset
//   bus (slave)  : req/htrans/hready_shared/refresh_req/refresh_done in;
//                  grant/grant_valid/owner_idx/refresh_ack (registered) and
//                  addr_block (combinational) out
module ahb_sdram_burst_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16
) (
    input  logic                      hclk,
    input  logic                      hreset,
    ahb_sdram_burst_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_MASTERS - 1);

    localparam logic [1:0] ST_IDLE    = ARB_IDLE;
    localparam logic [1:0] ST_OWN     = ARB_OWN;
    localparam logic [1:0] ST_REFRESH = ARB_REFRESH;

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic                   refresh_ack_q, refresh_ack_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                   ref_pend_q, ref_pend_d;
    logic                   addr_block;

    logic [IDX_W-1:0] winner;
    logic             found;

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .found  (found)
    );

    logic [1:0] own_trans;
    logic       beat, force_rel, rel_idle, rel_nonseq;

    assign own_trans  = bus.htrans[{owner_q, 1'b0} +: 2];
    assign beat       = bus.hready_shared && is_beat_trans(own_trans);
    assign force_rel  = (beat_cnt_q >= HOLD_LIMIT) || ref_pend_q || bus.refresh_req;
    // SEQ/BUSY or a stalled bus lock the tenure; only IDLE or a fresh NONSEQ end it.
    assign rel_idle   = bus.hready_shared && (own_trans == HTRANS_IDLE);
    assign rel_nonseq = bus.hready_shared && (own_trans == HTRANS_NONSEQ) && force_rel;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        owner_d       = owner_q;
        refresh_ack_d = refresh_ack_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        ref_pend_d    = ref_pend_q;
        addr_block    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.refresh_req) begin
                    state_d       = ST_REFRESH;
                    refresh_ack_d = 1'b1;
                    ref_pend_d    = 1'b0;
                end else if (found) begin
                    state_d       = ST_OWN;
                    grant_d       = NUM_MASTERS'(1) << winner;
                    grant_valid_d = 1'b1;
                    owner_d       = winner;
                    beat_cnt_d    = '0;
                end
            end
            ST_OWN: begin
                if (bus.refresh_req) begin
                    ref_pend_d = 1'b1;
                end
                if (rel_idle || rel_nonseq) begin
                    // Forced NONSEQ is held off the controller; the master retries later.
                    addr_block    = rel_nonseq;
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end else if (beat && (beat_cnt_q < HOLD_LIMIT)) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            ST_REFRESH: begin
                if (bus.refresh_done) begin
                    state_d       = ST_IDLE;
                    refresh_ack_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                refresh_ack_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            owner_q       <= '0;
            refresh_ack_q <= 1'b0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            ref_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            owner_q       <= owner_d;
            refresh_ack_q <= refresh_ack_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            ref_pend_q    <= ref_pend_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.owner_idx   = owner_q;
    assign bus.refresh_ack = refresh_ack_q;
    assign bus.addr_block  = addr_block;

endmodule
